id_stage: RTL and testbench

Instruction-decode stage placed directly downstream of the instruction-fetch stage. It captures the 16-bit `instrucao` word into an IF/ID pipeline register, decodes it into register addresses, a sign-extended immediate and control strobes for the execute stage, and applies flow control toward fetch. Flow control covers a one-bubble load-use interlock, branch flush, downstream stall and a HALT state.

---
 rtl/id_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID capture, field decode, sign-extended immediate,
// load-use interlock, branch flush, downstream stall and HALT handling.
module id_stage #(
  parameter int unsigned BUBBLE_CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             instrucao,
  input  logic                    if_valid,
  input  logic                    flush,
  input  logic                    ex_stall,
  output logic                    hold_if,
  output logic                    id_valid,
  output logic [3:0]              op,
  output logic [3:0]              rd_addr,
  output logic [3:0]              rs_addr,
  output logic [3:0]              rt_addr,
  output logic [15:0]             imm16,
  output logic                    reg_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    branch,
  output logic                    jump,
  output logic                    illegal,
  output logic                    halted,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_INTERLOCK = 2'd1,
    S_HALTED    = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm16;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  state_t state_q, state_d;
  dec_t   dec_c, id_q;
  logic   uses_rs_rt_c, uses_rd_c, hazard_c, is_halt_c;
  logic   load_en_c, load_bubble_c, cnt_inc_c;

  // Combinational decode of the incoming fetch word
  always_comb begin
    dec_c        = '0;
    uses_rs_rt_c = 1'b0;
    uses_rd_c    = 1'b0;
    dec_c.valid  = 1'b1;
    dec_c.op     = instrucao[15:12];
    dec_c.rd     = instrucao[11:8];
    dec_c.rs     = instrucao[7:4];
    dec_c.rt     = instrucao[3:0];
    case (instrucao[15:12])
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_c.reg_write = 1'b1;
        uses_rs_rt_c    = 1'b1;
      end
      OP_ADDI: begin
        dec_c.reg_write = 1'b1;
        dec_c.imm16     = {{8{instrucao[7]}}, instrucao[7:0]};
        uses_rd_c       = 1'b1;
      end
      OP_LW: begin
        dec_c.reg_write = 1'b1;
        dec_c.mem_read  = 1'b1;
        uses_rs_rt_c    = 1'b1;
      end
      OP_SW: begin
        dec_c.mem_write = 1'b1;
        uses_rs_rt_c    = 1'b1;
      end
      OP_JMP: begin
        dec_c.jump  = 1'b1;
        dec_c.imm16 = {{4{instrucao[11]}}, instrucao[11:0]};
      end
      OP_BEQZ: begin
        dec_c.branch = 1'b1;
        dec_c.imm16  = {{8{instrucao[7]}}, instrucao[7:0]};
        uses_rd_c    = 1'b1;
      end
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: dec_c.illegal = 1'b1;
      default: ;
    endcase
  end

  // Load-use: a valid LW writing a non-zero register feeds the incoming word
  always_comb begin
    hazard_c = 1'b0;
    if (id_q.valid && (id_q.op == OP_LW) && (id_q.rd != 4'h0) && if_valid) begin
      hazard_c = (uses_rs_rt_c && ((dec_c.rs == id_q.rd) || (dec_c.rt == id_q.rd))) ||
                 (uses_rd_c && (dec_c.rd == id_q.rd));
    end
  end

  assign is_halt_c = if_valid && (instrucao[15:12] == OP_HALT);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      if (state_q != S_HALTED) state_d = S_RUN;
    end else if (!ex_stall) begin
      case (state_q)
        S_RUN, S_INTERLOCK: begin
          if (hazard_c)       state_d = S_INTERLOCK;
          else if (is_halt_c) state_d = S_HALTED;
          else                state_d = S_RUN;
        end
        default: state_d = S_HALTED;
      endcase
    end
  end

  // Pipeline-register controls and fetch hold
  always_comb begin
    load_en_c     = 1'b0;
    load_bubble_c = 1'b0;
    cnt_inc_c     = 1'b0;
    if (flush) begin
      load_en_c     = 1'b1;
      load_bubble_c = 1'b1;
    end else if (!ex_stall) begin
      load_en_c = 1'b1;
      if ((state_q == S_HALTED) || hazard_c || !if_valid) load_bubble_c = 1'b1;
      cnt_inc_c = hazard_c && (state_q != S_HALTED);
    end
    hold_if = (state_q == S_HALTED) || (!flush && (hazard_c || ex_stall));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_q       <= '0;
      bubble_cnt <= '0;
    end else if (load_en_c) begin
      id_q <= load_bubble_c ? '0 : dec_c;
      if (cnt_inc_c && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + BUBBLE_CNT_W'(1);
    end
  end

  assign id_valid  = id_q.valid;
  assign op        = id_q.op;
  assign rd_addr   = id_q.rd;
  assign rs_addr   = id_q.rs;
  assign rt_addr   = id_q.rt;
  assign imm16     = id_q.imm16;
  assign reg_write = id_q.reg_write;
  assign mem_read  = id_q.mem_read;
  assign mem_write = id_q.mem_write;
  assign branch    = id_q.branch;
  assign jump      = id_q.jump;
  assign illegal   = id_q.illegal;
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: table-driven decode vectors plus hand-written
// interlock, flush, stall, HALT and counter-saturation sequences.
module tb_id_stage;
  localparam int unsigned BW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   instrucao = '0;
  logic          if_valid = 1'b0, flush = 1'b0, ex_stall = 1'b0;
  logic          hold_if, id_valid, reg_write, mem_read, mem_write, branch, jump, illegal, halted;
  logic [3:0]    op, rd_addr, rs_addr, rt_addr;
  logic [15:0]   imm16;
  logic [BW-1:0] bubble_cnt;
  logic [5:0]    strb;

  always #5 clock = ~clock;

  id_stage #(.BUBBLE_CNT_W(BW)) dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .if_valid(if_valid),
    .flush(flush), .ex_stall(ex_stall), .hold_if(hold_if), .id_valid(id_valid),
    .op(op), .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr), .imm16(imm16),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .illegal(illegal), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  assign strb = {reg_write, mem_read, mem_write, branch, jump, illegal};

  int checks = 0;
  int errors = 0;
  int exp_bub = 0;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] imm;
    logic [5:0]  strb;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic v, input logic f, input logic s);
    instrucao = i; if_valid = v; flush = f; ex_stall = s;
    #1;
  endtask

  task automatic idle();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".id_valid"}, 32'(id_valid), 0);
    chk({tag, ".fields"}, 32'({op, rd_addr, rs_addr, rt_addr}), 0);
    chk({tag, ".imm16"}, 32'(imm16), 0);
    chk({tag, ".strobes"}, 32'(strb), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 0);
    chk({tag, ".hold_if"}, 32'(hold_if), 0);
  endtask

  // LW in the output register, then nxt arrives; hz says whether a bubble is expected
  task automatic load_use(input logic [15:0] lw, input logic [15:0] nxt, input logic hz);
    logic [3:0] nop;
    nop = nxt[15:12];
    drive(lw, 1'b1, 1'b0, 1'b0);
    tick();
    drive(nxt, 1'b1, 1'b0, 1'b0);
    chk("lu.hold_if", 32'(hold_if), 32'(hz));
    tick();
    if (hz) begin
      exp_bub = (exp_bub < 255) ? exp_bub + 1 : 255;
      chk("lu.bubble_valid", 32'(id_valid), 0);
      chk("lu.bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
      chk("lu.hold_released", 32'(hold_if), 0);
      tick();
    end
    chk("lu.issue_valid", 32'(id_valid), 1);
    chk("lu.issue_op", 32'(op), 32'(nop));
    chk("lu.cnt_after", 32'(bubble_cnt), 32'(exp_bub));
    idle();
    tick();
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 6'b000000};
    vecs[1]  = '{16'h1312, 4'h1, 4'h3, 4'h1, 4'h2, 16'h0000, 6'b100000};
    vecs[2]  = '{16'h2456, 4'h2, 4'h4, 4'h5, 4'h6, 16'h0000, 6'b100000};
    vecs[3]  = '{16'h3ABC, 4'h3, 4'hA, 4'hB, 4'hC, 16'h0000, 6'b100000};
    vecs[4]  = '{16'h4123, 4'h4, 4'h1, 4'h2, 4'h3, 16'h0000, 6'b100000};
    vecs[5]  = '{16'h5AF0, 4'h5, 4'hA, 4'hF, 4'h0, 16'hFFF0, 6'b100000};
    vecs[6]  = '{16'h5A05, 4'h5, 4'hA, 4'h0, 4'h5, 16'h0005, 6'b100000};
    vecs[7]  = '{16'h6350, 4'h6, 4'h3, 4'h5, 4'h0, 16'h0000, 6'b110000};
    vecs[8]  = '{16'h7352, 4'h7, 4'h3, 4'h5, 4'h2, 16'h0000, 6'b001000};
    vecs[9]  = '{16'h8800, 4'h8, 4'h8, 4'h0, 4'h0, 16'hF800, 6'b000010};
    vecs[10] = '{16'h87FF, 4'h8, 4'h7, 4'hF, 4'hF, 16'h07FF, 6'b000010};
    vecs[11] = '{16'h9380, 4'h9, 4'h3, 4'h8, 4'h0, 16'hFF80, 6'b000100};
    vecs[12] = '{16'hB000, 4'hB, 4'h0, 4'h0, 4'h0, 16'h0000, 6'b000001};
    vecs[13] = '{16'hE123, 4'hE, 4'h1, 4'h2, 4'h3, 16'h0000, 6'b000001};

    tick(); tick();
    reset = 1'b0;
    idle();
    chk_reset_state("reset");

    // Decode table: each word followed by an invalid-fetch bubble
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].instr, 1'b1, 1'b0, 1'b0);
      chk("vec.hold_if", 32'(hold_if), 0);
      tick();
      chk("vec.id_valid", 32'(id_valid), 1);
      chk("vec.op", 32'(op), 32'(vecs[i].op));
      chk("vec.regs", 32'({rd_addr, rs_addr, rt_addr}), 32'({vecs[i].rd, vecs[i].rs, vecs[i].rt}));
      chk("vec.imm16", 32'(imm16), 32'(vecs[i].imm));
      chk("vec.strobes", 32'(strb), 32'(vecs[i].strb));
      idle();
      tick();
      chk("vec.invalid_bubble", 32'(id_valid), 0);
    end
    chk("vec.no_count", 32'(bubble_cnt), 0);

    load_use(16'h6350, 16'h1432, 1'b1);
    load_use(16'h6050, 16'h1002, 1'b0);
    load_use(16'h6350, 16'h9300, 1'b1);
    load_use(16'h6350, 16'h5305, 1'b1);
    load_use(16'h6350, 16'h7132, 1'b1);
    load_use(16'h6350, 16'h8300, 1'b0);
    load_use(16'h6350, 16'h1342, 1'b0);
    load_use(16'h6350, 16'h6435, 1'b1);

    // Flush wins over a pending hazard: bubble, word dropped, nothing counted
    drive(16'h6350, 1'b1, 1'b0, 1'b0); tick();
    drive(16'h1432, 1'b1, 1'b1, 1'b0);
    chk("flush.hold_if", 32'(hold_if), 0);
    tick();
    chk("flush.bubble", 32'(id_valid), 0);
    chk("flush.cnt", 32'(bubble_cnt), 32'(exp_bub));
    drive(16'h2111, 1'b1, 1'b0, 1'b0); tick();
    chk("flush.next_valid", 32'(id_valid), 1);
    chk("flush.next_op", 32'(op), 2);
    idle(); tick();

    // Stall overrides hazard; hazard re-evaluated after release
    drive(16'h6350, 1'b1, 1'b0, 1'b0); tick();
    drive(16'h1432, 1'b1, 1'b0, 1'b1);
    chk("sh.hold_if", 32'(hold_if), 1);
    tick();
    chk("sh.held_op", 32'(op), 6);
    chk("sh.cnt_held", 32'(bubble_cnt), 32'(exp_bub));
    drive(16'h1432, 1'b1, 1'b0, 1'b0);
    chk("sh.hazard_hold", 32'(hold_if), 1);
    tick();
    exp_bub++;
    chk("sh.bubble", 32'(id_valid), 0);
    chk("sh.cnt", 32'(bubble_cnt), 32'(exp_bub));
    tick();
    chk("sh.issue_op", 32'(op), 1);
    idle(); tick();

    // Three-cycle stall mid-stream: outputs frozen, nothing lost or duplicated
    drive(16'h1312, 1'b1, 1'b0, 1'b0); tick();
    drive(16'h2456, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'h3789, 1'b1, 1'b0, 1'b1);
      chk("stall.hold_if", 32'(hold_if), 1);
      tick();
      chk("stall.op", 32'(op), 2);
      chk("stall.regs", 32'({rd_addr, rs_addr, rt_addr}), 32'h456);
    end
    drive(16'h3789, 1'b1, 1'b0, 1'b0);
    chk("stall.release_hold", 32'(hold_if), 0);
    tick();
    chk("stall.next_op", 32'(op), 3);
    drive(16'h4ABC, 1'b1, 1'b0, 1'b0); tick();
    chk("stall.last_op", 32'(op), 4);
    idle(); tick();

    // HALT: issues once, then bubbles with fetch held; flush cannot release it
    drive(16'hF000, 1'b1, 1'b0, 1'b0); tick();
    drive(16'h1312, 1'b1, 1'b0, 1'b0);
    chk("halt.valid", 32'(id_valid), 1);
    chk("halt.op", 32'(op), 15);
    chk("halt.strobes", 32'(strb), 0);
    chk("halt.halted", 32'(halted), 1);
    chk("halt.hold_if", 32'(hold_if), 1);
    tick();
    chk("halt.bubble", 32'(id_valid), 0);
    drive(16'h1312, 1'b1, 1'b1, 1'b0);
    chk("halt.flush_hold", 32'(hold_if), 1);
    tick();
    chk("halt.after_flush", 32'(halted), 1);
    chk("halt.after_flush_valid", 32'(id_valid), 0);
    reset = 1'b1; idle(); tick();
    reset = 1'b0;
    chk_reset_state("halt_reset");
    exp_bub = 0;

    // Saturation of the bubble counter
    for (int i = 0; i < 256; i++) begin
      drive(16'h6350, 1'b1, 1'b0, 1'b0); tick();
      drive(16'h1432, 1'b1, 1'b0, 1'b0); tick();
      tick();
      if (i == 253) chk("sat.254", 32'(bubble_cnt), 254);
    end
    chk("sat.cnt", 32'(bubble_cnt), 255);
    chk("sat.last_issue", 32'(op), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
